mdr_mem_port: RTL and testbench
===============================

Name: mdr_mem_port

Overview:
- Parametrised memory data register with its own memory-bus handshake.
- Sits between the datapath (MAR/accumulator side) and a variable-latency memory.
- Holds load/store data and a direct datapath write path, as before.
- Adds a request/acknowledge FSM, busy/done status for the control unit, and a wait-state timeout.

Parameters:
- DATA_W, 16, data width of MDR and memory data bus
- ADDR_W, 16, memory address width
- TIMEOUT, 255, max wait cycles for mem_ack; 0 disables timeout

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- mdr_write  in  1  load mdr_in into MDR (datapath write)
- mdr_in  in  DATA_W  datapath data to MDR
- rd_start  in  1  start memory read into MDR at addr
- wr_start  in  1  start memory write of MDR contents to addr
- addr  in  ADDR_W  address from MAR, sampled on start
- mdr_out  out  DATA_W  current MDR contents
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse on successful completion
- timeout_err  out  1  sticky wait-timeout flag
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  ADDR_W  registered request address
- mem_wdata  out  DATA_W  registered store data
- mem_ack  in  1  memory acknowledge, single cycle
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1

Behaviour:
- Reset values:
  - all outputs 0: mdr_out, busy, done, timeout_err, mem_req, mem_we, mem_addr, mem_wdata
  - FSM in IDLE, wait counter 0
  - Reset mid-transaction aborts immediately: mem_req drops the next cycle, no done.
- FSM states: IDLE, RD_WAIT, WR_WAIT. All outputs are registered.
- IDLE:
  - mdr_write=1: mdr_out <= mdr_in.
  - rd_start=1: mem_addr <= addr, mem_we <= 0, mem_req <= 1, busy <= 1, go to RD_WAIT.
  - wr_start=1: mem_addr <= addr, mem_wdata <= MDR value, mem_we <= 1, mem_req <= 1, busy <= 1, go to WR_WAIT.
    - The MDR value is mdr_in if mdr_write is also set, else mdr_out.
  - rd_start and wr_start together: the read wins and the write is dropped.
  - mem_ack in IDLE is ignored.
- RD_WAIT / WR_WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - rd_start, wr_start and mdr_write are ignored.
  - The wait counter increments each cycle.
  - On mem_ack=1:
    - RD_WAIT only: mdr_out <= mem_rdata.
    - Then: mem_req <= 0, busy <= 0, done <= 1 for one cycle, counter <= 0, go to IDLE.
- Latency:
  - rd_start sampled at edge 0; mem_req and busy high after edge 0.
  - mem_ack sampled at edge 1 (zero wait states): mdr_out valid, done=1 and busy=0 after edge 1.
  - Each wait state adds one cycle.
  - A new start is accepted in the same cycle done is high, since the FSM is already in IDLE.
- Timeout (TIMEOUT>0):
  - Trigger: counter reaches TIMEOUT with no ack, i.e. TIMEOUT cycles of mem_req without ack.
  - Response: mem_req <= 0, busy <= 0, timeout_err <= 1, no done, mdr_out unchanged, go to IDLE.
  - An ack in the same cycle the counter reaches TIMEOUT counts as success.
  - timeout_err stays set until reset.
  - The counter is ceil(log2(TIMEOUT+1)) bits wide and saturates; it never wraps.
- TIMEOUT=0: waits indefinitely.

Optional Feature:
- Macro: MDR_MEM_PORT_PARITY_EN
- Defined:
  - Adds input mem_rpar (1), even parity over mem_rdata.
  - Adds output par_err (1), sticky until reset.
  - Adds output mem_wpar (1), registered alongside mem_wdata.
  - On a read ack with parity mismatch: mdr_out is still loaded, par_err <= 1, done still pulses.
- Undefined: none of these ports or this logic exist.

Test Plan:
- Reset then idle: all outputs 0; mem_ack=1 pulses in IDLE -> no state change, done=0.
- mdr_write=1, mdr_in=16'hBEEF -> mdr_out=16'hBEEF next cycle; then rd_start, addr=16'h0040, mem_ack after 3 wait cycles with mem_rdata=16'h1234 -> mem_req high for 4 cycles with mem_addr=16'h0040, mem_we=0, then mdr_out=16'h1234, done pulse of 1 cycle, busy low.
- wr_start + mdr_write (mdr_in=16'hA5A5), addr=16'h0100, ack at zero wait -> mem_we=1, mem_wdata=16'hA5A5, done the cycle after ack, mdr_out=16'hA5A5.
- rd_start and wr_start together -> mem_we=0 (read only); mdr_write=1 during RD_WAIT -> mdr_out unchanged until the ack data arrives.
- TIMEOUT=4, rd_start, no ack -> mem_req high 4 cycles then low, timeout_err=1, done never asserted, mdr_out unchanged; timeout_err cleared only by reset.
- Reset asserted in WR_WAIT -> next cycle all outputs 0, FSM IDLE; a late mem_ack is ignored.

Source files
------------

// File: rtl/mdr_mem_port.sv
// Memory data register with its own request/acknowledge bus handshake and wait-state timeout.
// Optional even-parity checking/generation is enabled by defining MDR_MEM_PORT_PARITY_EN.
module mdr_mem_port #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mdr_write,
   input  logic [DATA_W-1:0] mdr_in,
   input  logic              rd_start,
   input  logic              wr_start,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] mdr_out,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
`ifdef MDR_MEM_PORT_PARITY_EN
   input  logic              mem_rpar,
   output logic              par_err,
   output logic              mem_wpar,
`endif
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   // With the timeout disabled the counter is unused but kept one bit wide.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              terr_q, terr_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef MDR_MEM_PORT_PARITY_EN
   logic              perr_q, perr_d;
   logic              wpar_q, wpar_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mdr_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         terr_q  <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef MDR_MEM_PORT_PARITY_EN
         perr_q  <= 1'b0;
         wpar_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mdr_q   <= mdr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         terr_q  <= terr_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef MDR_MEM_PORT_PARITY_EN
         perr_q  <= perr_d;
         wpar_q  <= wpar_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mdr_d   = mdr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      terr_d  = terr_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef MDR_MEM_PORT_PARITY_EN
      perr_d  = perr_q;
      wpar_d  = wpar_q;
`endif
      case (state_q)
         IDLE: begin
            if (mdr_write) mdr_d = mdr_in;
            // A simultaneous read and write request resolves to the read.
            if (rd_start) begin
               addr_d  = addr;
               we_d    = 1'b0;
               req_d   = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = RD_WAIT;
            end else if (wr_start) begin
               addr_d  = addr;
               wdata_d = mdr_write ? mdr_in : mdr_q;
`ifdef MDR_MEM_PORT_PARITY_EN
               wpar_d  = ^(mdr_write ? mdr_in : mdr_q);
`endif
               we_d    = 1'b1;
               req_d   = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = WR_WAIT;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (mem_ack) begin
               if (state_q == RD_WAIT) begin
                  mdr_d = mem_rdata;
`ifdef MDR_MEM_PORT_PARITY_EN
                  if ((^mem_rdata) != mem_rpar) perr_d = 1'b1;
`endif
               end
               req_d   = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
               // This cycle completes TIMEOUT cycles of unanswered request.
               req_d   = 1'b0;
               busy_d  = 1'b0;
               terr_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mdr_out     = mdr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = terr_q;
   assign mem_req     = req_q;
   assign mem_we      = we_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
`ifdef MDR_MEM_PORT_PARITY_EN
   assign par_err     = perr_q;
   assign mem_wpar    = wpar_q;
`endif

endmodule

// File: tb/tb_mdr_mem_port.sv
// Directed self-checking bench for mdr_mem_port, built with TIMEOUT=4 so the
// wait-state timeout and its ack-on-boundary case are both reachable.
module tb_mdr_mem_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        mdr_write;
   logic [15:0] mdr_in;
   logic        rd_start;
   logic        wr_start;
   logic [15:0] addr;
   logic [15:0] mdr_out;
   logic        busy;
   logic        done;
   logic        timeout_err;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;
`ifdef MDR_MEM_PORT_PARITY_EN
   logic        mem_rpar;
   logic        par_err;
   logic        mem_wpar;
   assign mem_rpar = ^mem_rdata;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mdr_mem_port #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut (
      .clk(clk),
      .reset(reset),
      .mdr_write(mdr_write),
      .mdr_in(mdr_in),
      .rd_start(rd_start),
      .wr_start(wr_start),
      .addr(addr),
      .mdr_out(mdr_out),
      .busy(busy),
      .done(done),
      .timeout_err(timeout_err),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
`ifdef MDR_MEM_PORT_PARITY_EN
      .mem_rpar(mem_rpar),
      .par_err(par_err),
      .mem_wpar(mem_wpar),
`endif
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
   );

   // Advance one rising edge, then settle so outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; mdr_write = 1'b0; mdr_in = '0; rd_start = 1'b0; wr_start = 1'b0;
      addr = '0; mem_ack = 1'b0; mem_rdata = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      checks++;
      if ({mdr_out, busy, done, timeout_err, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got mdr=%h busy=%b done=%b terr=%b req=%b we=%b addr=%h wdata=%h, expected all 0",
                  mdr_out, busy, done, timeout_err, mem_req, mem_we, mem_addr, mem_wdata);
      end
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      tick(); tick();
      mem_ack = 1'b0;
      checks++;
      if ({busy, done, mem_req, mdr_out} !== '0) begin
         failures++;
         $display("[TB] FAIL idle_ack_ignored: got busy=%b done=%b req=%b mdr=%h, expected 0 0 0 0000",
                  busy, done, mem_req, mdr_out);
      end
   endtask

   task automatic test_read();
      int reqCycles = 0;
      mdr_write = 1'b1; mdr_in = 16'hBEEF;
      tick();
      mdr_write = 1'b0;
      checks++;
      if (mdr_out !== 16'hBEEF) begin
         failures++;
         $display("[TB] FAIL mdr_write: got %h expected BEEF", mdr_out);
      end
      rd_start = 1'b1; addr = 16'h0040;
      tick();
      rd_start = 1'b0; addr = 16'hFFFF;
      checks++;
      if ({mem_req, busy, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 16'h0040}) begin
         failures++;
         $display("[TB] FAIL read_request: got req=%b busy=%b we=%b addr=%h, expected 1 1 0 0040",
                  mem_req, busy, mem_we, mem_addr);
      end
      if (mem_req) reqCycles++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (mem_req && mem_addr == 16'h0040 && !done) reqCycles++;
      end
      // Ack lands exactly when the wait counter reaches TIMEOUT: must be a success.
      mem_ack = 1'b1; mem_rdata = 16'h1234;
      tick();
      mem_ack = 1'b0; mem_rdata = 16'h0000;
      checks++;
      if (reqCycles !== 4) begin
         failures++;
         $display("[TB] FAIL read_req_cycles: got %0d expected 4", reqCycles);
      end
      checks++;
      if ({mdr_out, done, busy, mem_req, timeout_err} !== {16'h1234, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("[TB] FAIL read_complete: got mdr=%h done=%b busy=%b req=%b terr=%b, expected 1234 1 0 0 0",
                  mdr_out, done, busy, mem_req, timeout_err);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL done_one_cycle: got %b expected 0", done);
      end
   endtask

   task automatic test_write();
      wr_start = 1'b1; mdr_write = 1'b1; mdr_in = 16'hA5A5; addr = 16'h0100;
      tick();
      wr_start = 1'b0; mdr_write = 1'b0; mdr_in = 16'h0000;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mdr_out} !== {1'b1, 1'b1, 16'h0100, 16'hA5A5, 16'hA5A5}) begin
         failures++;
         $display("[TB] FAIL write_request: got req=%b we=%b addr=%h wdata=%h mdr=%h, expected 1 1 0100 A5A5 A5A5",
                  mem_req, mem_we, mem_addr, mem_wdata, mdr_out);
      end
      mem_ack = 1'b1; mem_rdata = 16'h7777;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({done, busy, mem_req, mdr_out} !== {1'b1, 1'b0, 1'b0, 16'hA5A5}) begin
         failures++;
         $display("[TB] FAIL write_complete: got done=%b busy=%b req=%b mdr=%h, expected 1 0 0 A5A5",
                  done, busy, mem_req, mdr_out);
      end
      tick();
   endtask

   task automatic test_collision();
      rd_start = 1'b1; wr_start = 1'b1; addr = 16'h0200;
      tick();
      rd_start = 1'b0; wr_start = 1'b0;
      checks++;
      if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0200}) begin
         failures++;
         $display("[TB] FAIL read_wins: got req=%b we=%b addr=%h, expected 1 0 0200", mem_req, mem_we, mem_addr);
      end
      mdr_write = 1'b1; mdr_in = 16'hFFFF;
      tick();
      checks++;
      if (mdr_out !== 16'hA5A5) begin
         failures++;
         $display("[TB] FAIL write_ignored_in_wait: got %h expected A5A5", mdr_out);
      end
      mem_ack = 1'b1; mem_rdata = 16'h5A5A;
      tick();
      mem_ack = 1'b0; mdr_write = 1'b0;
      checks++;
      if ({mdr_out, done} !== {16'h5A5A, 1'b1}) begin
         failures++;
         $display("[TB] FAIL collision_read_data: got mdr=%h done=%b, expected 5A5A 1", mdr_out, done);
      end
   endtask

   task automatic test_back_to_back();
      rd_start = 1'b1; addr = 16'h0300;
      tick();
      rd_start = 1'b0;
      mem_ack = 1'b1; mem_rdata = 16'h0F0F;
      tick();
      mem_ack = 1'b0;
      // done is high now; a new start in this cycle must be accepted.
      wr_start = 1'b1; addr = 16'h0304;
      tick();
      wr_start = 1'b0;
      checks++;
      if ({busy, mem_req, mem_we, mem_addr, mem_wdata, done} !== {1'b1, 1'b1, 1'b1, 16'h0304, 16'h0F0F, 1'b0}) begin
         failures++;
         $display("[TB] FAIL back_to_back: got busy=%b req=%b we=%b addr=%h wdata=%h done=%b, expected 1 1 1 0304 0F0F 0",
                  busy, mem_req, mem_we, mem_addr, mem_wdata, done);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int reqCycles = 0;
      int doneSeen  = 0;
      rd_start = 1'b1; addr = 16'h0400; mem_rdata = 16'h9999;
      tick();
      rd_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (mem_req) reqCycles++;
         if (done) doneSeen++;
         tick();
      end
      checks++;
      if (reqCycles !== 4) begin
         failures++;
         $display("[TB] FAIL timeout_req_cycles: got %0d expected 4", reqCycles);
      end
      checks++;
      if ({timeout_err, busy, mem_req, doneSeen[0], mdr_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0F0F}) begin
         failures++;
         $display("[TB] FAIL timeout_state: got terr=%b busy=%b req=%b done_seen=%0d mdr=%h, expected 1 0 0 0 0F0F",
                  timeout_err, busy, mem_req, doneSeen, mdr_out);
      end
      rd_start = 1'b1; addr = 16'h0408;
      tick();
      rd_start = 1'b0;
      mem_ack = 1'b1; mem_rdata = 16'h4321;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({timeout_err, done, mdr_out} !== {1'b1, 1'b1, 16'h4321}) begin
         failures++;
         $display("[TB] FAIL timeout_sticky: got terr=%b done=%b mdr=%h, expected 1 1 4321", timeout_err, done, mdr_out);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL timeout_cleared_by_reset: got %b expected 0", timeout_err);
      end
   endtask

   task automatic test_reset_midwrite();
      mdr_write = 1'b1; mdr_in = 16'hC3C3; wr_start = 1'b1; addr = 16'h0500;
      tick();
      mdr_write = 1'b0; wr_start = 1'b0;
      checks++;
      if ({mem_req, mem_we, mem_wdata} !== {1'b1, 1'b1, 16'hC3C3}) begin
         failures++;
         $display("[TB] FAIL midwrite_request: got req=%b we=%b wdata=%h, expected 1 1 C3C3", mem_req, mem_we, mem_wdata);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({mdr_out, busy, done, timeout_err, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_midwrite: got mdr=%h busy=%b done=%b terr=%b req=%b we=%b addr=%h wdata=%h, expected all 0",
                  mdr_out, busy, done, timeout_err, mem_req, mem_we, mem_addr, mem_wdata);
      end
      mem_ack = 1'b1; mem_rdata = 16'h1111;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({done, busy, mem_req, mdr_out} !== '0) begin
         failures++;
         $display("[TB] FAIL late_ack_ignored: got done=%b busy=%b req=%b mdr=%h, expected 0 0 0 0000",
                  done, busy, mem_req, mdr_out);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_collision();
      test_back_to_back();
      test_timeout();
      test_reset_midwrite();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
